uart_tx_unit: RTL and testbench

UART_TX_UNIT -- requirements
Module: uart_tx_unit

---
 rtl/uart_tx_unit.sv | 135 +++++++++++++
 tb/tb_uart_tx_unit.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_unit.sv
// 8N1 UART transmitter: a byte FIFO feeding a four-state serialiser.
// txd comes straight from a flop that lags the FSM state by one clock.
module uart_tx_unit #(
   parameter int CLKS_PER_BIT = 868,
   parameter int FIFO_DEPTH   = 16
) (
   input  logic       clk,
   input  logic       rstn,
   input  logic [7:0] uart_tx_data,
   input  logic       uart_wr_en,
   output logic       full,
   output logic       txd,
   output logic       busy
);

   localparam int                PTR_W     = $clog2(FIFO_DEPTH);
   localparam int                CNT_W     = PTR_W + 1;
   localparam logic [15:0]       BAUD_LAST = 16'(CLKS_PER_BIT - 1);
   localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(FIFO_DEPTH);

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   state_t           state_q, state_d;
   logic [7:0]       mem [FIFO_DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
   logic [CNT_W-1:0] count_q;
   logic [15:0]      baud_q, baud_d;
   logic [2:0]       bit_q, bit_d;
   logic [7:0]       shift_q, shift_d;
   logic             txd_q, txd_d;
   logic             wr_accept, pop;

   // full looks only at the registered count, so a same-cycle pop never frees a slot early.
   assign full      = (count_q == CNT_FULL);
   assign wr_accept = uart_wr_en && !full;

   // NOTE: the storage array is not reset; pointers and count alone define which entries are valid.
   always_ff @(posedge clk) begin
      if (wr_accept) mem[wr_ptr_q] <= uart_tx_data;
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (wr_accept) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
         if (pop)       rd_ptr_q <= rd_ptr_q + PTR_W'(1);
         case ({wr_accept, pop})
            2'b10:   count_q <= count_q + CNT_W'(1);
            2'b01:   count_q <= count_q - CNT_W'(1);
            default: count_q <= count_q;
         endcase
      end
   end

   // NOTE: every always_comb output gets a default first, so no branch can infer a latch.
   always_comb begin
      state_d = state_q;
      baud_d  = baud_q;
      bit_d   = bit_q;
      shift_d = shift_q;
      pop     = 1'b0;
      txd_d   = 1'b1;
      unique case (state_q)
         IDLE: begin
            baud_d = '0;
            if (count_q != '0) begin
               pop     = 1'b1;
               shift_d = mem[rd_ptr_q];
               state_d = START;
            end
         end
         START: begin
            txd_d = 1'b0;
            if (baud_q == BAUD_LAST) begin
               baud_d  = '0;
               bit_d   = '0;
               state_d = DATA;
            end else begin
               baud_d = baud_q + 16'd1;
            end
         end
         DATA: begin
            txd_d = shift_q[0];
            if (baud_q == BAUD_LAST) begin
               baud_d  = '0;
               shift_d = {1'b0, shift_q[7:1]};
               bit_d   = bit_q + 3'd1;
               if (bit_q == 3'd7) state_d = STOP;
            end else begin
               baud_d = baud_q + 16'd1;
            end
         end
         STOP: begin
            if (baud_q == BAUD_LAST) begin
               baud_d = '0;
               // Chain straight into the next start bit when more data is queued.
               if (count_q != '0) begin
                  pop     = 1'b1;
                  shift_d = mem[rd_ptr_q];
                  state_d = START;
               end else begin
                  state_d = IDLE;
               end
            end else begin
               baud_d = baud_q + 16'd1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q <= IDLE;
         baud_q  <= '0;
         bit_q   <= '0;
         shift_q <= '0;
         txd_q   <= 1'b1;
      end else begin
         state_q <= state_d;
         baud_q  <= baud_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
         txd_q   <= txd_d;
      end
   end

   assign txd  = txd_q;
   assign busy = (state_q != IDLE) || (count_q != '0);

endmodule

// File: tb/tb_uart_tx_unit.sv
// Directed bench for uart_tx_unit: accepted bytes go into a scoreboard queue,
// a line monitor decodes each 8N1 frame and compares it against the queue head.
module tb_uart_tx_unit;

   localparam int CPB   = 4;
   localparam int DEPTH = 4;
   localparam int FRAME = 10 * CPB;

   logic       clk = 1'b0;
   logic       rstn = 1'b0;
   logic [7:0] uart_tx_data = 8'h00;
   logic       uart_wr_en = 1'b0;
   logic       full, txd, busy;

   int         total = 0;
   int         bad = 0;
   int         cyc = 0;
   int         last_wr_cyc = 0;
   logic [7:0] exp_q [$];
   int         start_q [$];

   bit         in_frame = 1'b0;
   bit         shape_ok = 1'b1;
   int         tick = 0;
   int         mon_bit = 0;
   int         frames_seen = 0;
   logic [7:0] rx = 8'h00;

   uart_tx_unit #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
      .clk          (clk),
      .rstn         (rstn),
      .uart_tx_data (uart_tx_data),
      .uart_wr_en   (uart_wr_en),
      .full         (full),
      .txd          (txd),
      .busy         (busy)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc++;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Line monitor: samples on the falling edge, checks every sample of the frame.
   always @(negedge clk) begin
      if (!rstn) begin
         in_frame = 1'b0;
      end else if (!in_frame) begin
         if (txd === 1'b0) begin
            in_frame = 1'b1;
            tick     = 1;
            shape_ok = 1'b1;
            rx       = 8'h00;
            start_q.push_back(cyc);
            frames_seen++;
         end
      end else begin
         mon_bit = tick / CPB;
         if (mon_bit == 0) begin
            if (txd !== 1'b0) shape_ok = 1'b0;
         end else if (mon_bit <= 8) begin
            if (tick % CPB == 0) rx[mon_bit-1] = txd;
            else if (txd !== rx[mon_bit-1]) shape_ok = 1'b0;
         end else begin
            if (txd !== 1'b1) shape_ok = 1'b0;
         end
         tick++;
         if (tick == FRAME) begin
            in_frame = 1'b0;
            check("frame_shape", 32'(shape_ok), 32'd1);
            check("frame_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) check("frame_byte", 32'(rx), 32'(exp_q.pop_front()));
         end
      end
   end

   task automatic write_byte(input logic [7:0] b, input bit accept);
      uart_wr_en   = 1'b1;
      uart_tx_data = b;
      @(posedge clk);
      #1;
      last_wr_cyc = cyc;
      if (accept) exp_q.push_back(b);
      uart_wr_en   = 1'b0;
      uart_tx_data = 8'($urandom);
   endtask

   task automatic wait_cyc(input int c);
      while (cyc < c) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic drain(input string tag);
      int n;
      n = 0;
      while ((exp_q.size() != 0 || in_frame || busy) && n < 2000) begin
         @(posedge clk);
         #1;
         n++;
      end
      check({tag, "_drain"}, 32'(n < 2000), 32'd1);
   endtask

   initial begin
      int w0;
      int fb;
      bit low_seen;

      // Reset state
      repeat (3) @(negedge clk);
      check("rst_txd", 32'(txd), 32'd1);
      check("rst_full", 32'(full), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      rstn = 1'b1;

      // Single byte written on the first edge after release
      start_q.delete();
      write_byte(8'hA5, 1'b1);
      w0 = last_wr_cyc;
      check("a5_busy_after_write", 32'(busy), 32'd1);
      drain("a5");
      check("a5_frames", 32'(start_q.size()), 32'd1);
      check("a5_start_latency", 32'((start_q.size() > 0) ? start_q[0] : -1), 32'(w0 + 2));
      repeat (5) @(posedge clk);
      #1;
      check("a5_busy_after", 32'(busy), 32'd0);
      check("a5_txd_idle", 32'(txd), 32'd1);

      // Back-to-back frames with no idle gap
      start_q.delete();
      write_byte(8'h00, 1'b1);
      w0 = last_wr_cyc;
      write_byte(8'hFF, 1'b1);
      drain("b2b");
      check("b2b_frames", 32'(start_q.size()), 32'd2);
      check("b2b_first_start", 32'((start_q.size() > 0) ? start_q[0] : -1), 32'(w0 + 2));
      check("b2b_period", 32'((start_q.size() > 1) ? start_q[1] - start_q[0] : -1), 32'(FRAME));

      // Overfill: 0x06 dropped while full, then a write dropped on a pop cycle
      start_q.delete();
      for (int i = 1; i <= 6; i++) begin
         write_byte(8'(i), i <= 5);
         if (i == 1) w0 = last_wr_cyc;
         check($sformatf("fill_full_%0d", i), 32'(full), 32'(i >= 5));
      end
      wait_cyc(w0 + FRAME);
      check("pop_cycle_full_before", 32'(full), 32'd1);
      write_byte(8'h77, 1'b0);
      check("pop_cycle_full_after", 32'(full), 32'd0);
      drain("fill");
      check("fill_frames", 32'(start_q.size()), 32'd5);
      check("fill_span", 32'((start_q.size() > 4) ? start_q[4] - start_q[0] : -1), 32'(4 * FRAME));

      // Reset during data bit 3 with two bytes queued
      start_q.delete();
      write_byte(8'h00, 1'b1);
      w0 = last_wr_cyc;
      write_byte(8'h11, 1'b1);
      write_byte(8'h22, 1'b1);
      wait_cyc(w0 + 2 + 3 * CPB + CPB + 1);
      check("midframe_txd_low", 32'(txd), 32'd0);
      rstn = 1'b0;
      #1;
      check("midframe_rst_txd", 32'(txd), 32'd1);
      exp_q.delete();
      repeat (3) @(posedge clk);
      #1;
      check("midframe_rst_full", 32'(full), 32'd0);
      check("midframe_rst_busy", 32'(busy), 32'd0);
      rstn = 1'b1;
      fb = frames_seen;
      low_seen = 1'b0;
      repeat (60) begin
         @(posedge clk);
         #1;
         if (txd !== 1'b1) low_seen = 1'b1;
      end
      check("post_rst_busy", 32'(busy), 32'd0);
      check("post_rst_full", 32'(full), 32'd0);
      check("post_rst_line_quiet", 32'(low_seen), 32'd0);
      check("post_rst_no_frames", 32'(frames_seen), 32'(fb));

      // Pointer wrap: 3 bytes, drain, 3 more
      start_q.delete();
      write_byte(8'h31, 1'b1);
      write_byte(8'h32, 1'b1);
      write_byte(8'h33, 1'b1);
      drain("wrap_a");
      write_byte(8'hC4, 1'b1);
      write_byte(8'hC5, 1'b1);
      write_byte(8'hC6, 1'b1);
      drain("wrap_b");
      check("wrap_frames", 32'(start_q.size()), 32'd6);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

endmodule
